decomp_cascade_logic: RTL and testbench

Cascade glue on the decompression path, the inverse of the compression-side cascade. It accepts the byte stream from the huffman decoder and packs it little-endian into 32-bit words tagged with a valid-byte count. It writes these words into the LZ4 decoder input FIFO. It splits the stream into statistic blocks of programmable length, flushes partial words at block and stream ends, and reports completion.

---
 rtl/decomp_cascade_logic.sv | 169 ++++++++++++++++
 tb/tb_decomp_cascade_logic.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decomp_cascade_logic.sv
// Decompression-side cascade glue: packs the huffman-decoded byte stream
// little-endian into 32-bit words tagged with {valid_bytes-1}, writes them
// into the LZ4 decoder input FIFO, splits the stream into statistic blocks
// and flushes partial words at block and stream ends.
module decomp_cascade_logic #(
    parameter int unsigned FIFO_W = 34,
    parameter int unsigned LEN_W  = 17
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              start_decompress,
    input  logic [LEN_W-1:0]  block_len,
    input  logic              block_len_valid,
    input  logic [7:0]        hd_data,
    input  logic              hd_valid,
    input  logic              hd_end,
    output logic              hd_ready,
    output logic [FIFO_W-1:0] lz4_data,
    output logic              lz4_wr,
    input  logic              lz4_full,
    output logic              blk_done,
    output logic              done,
    output logic [31:0]       total_bytes
);

    localparam int unsigned CNT_W  = 2;
    localparam int unsigned DATA_W = FIFO_W - CNT_W;
    localparam int unsigned BCNT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_LEN = 3'd1,
        S_PACK     = 3'd2,
        S_FLUSH    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_pack;
    logic [BCNT_W-1:0]   r_bcnt;
    logic [LEN_W-1:0]    r_rem;
    logic                r_pend;
    logic [DATA_W-1:0]   r_pend_data;
    logic [CNT_W-1:0]    r_pend_cnt;
    logic                r_end;
    logic [FIFO_W-1:0]   r_lz4_data;
    logic                r_lz4_wr;
    logic                r_blk_done;
    logic                r_done;
    logic [31:0]         r_total;

    logic                w_hd_ready;
    logic                w_accept;
    logic                w_wr_go;
    logic                w_last_blk;
    logic                w_word_done;
    logic [BCNT_W-1:0]   w_bcnt_inc;
    logic [LEN_W-1:0]    w_rem_dec;
    logic [DATA_W-1:0]   w_word;

    // Byte acceptance: only while packing, and only if the pending slot can drain.
    assign w_hd_ready  = (r_state == S_PACK) && (!r_pend || !lz4_full);
    assign w_accept    = hd_valid && w_hd_ready;
    assign w_wr_go     = r_pend && !lz4_full;
    assign w_bcnt_inc  = r_bcnt + BCNT_W'(1);
    assign w_rem_dec   = r_rem - LEN_W'(1);
    assign w_last_blk  = (r_rem == LEN_W'(1));
    assign w_word_done = (w_bcnt_inc == BCNT_W'(4)) || w_last_blk || hd_end;

    // Current pack register with the incoming byte dropped into lane bcnt.
    always_comb begin
        w_word = r_pack;
        case (r_bcnt[1:0])
            2'd0:    w_word[7:0]   = hd_data;
            2'd1:    w_word[15:8]  = hd_data;
            2'd2:    w_word[23:16] = hd_data;
            default: w_word[31:24] = hd_data;
        endcase
    end

    // Control FSM, packing datapath and registered FIFO/status outputs.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state     <= S_IDLE;
            r_pack      <= '0;
            r_bcnt      <= '0;
            r_rem       <= '0;
            r_pend      <= 1'b0;
            r_pend_data <= '0;
            r_pend_cnt  <= '0;
            r_end       <= 1'b0;
            r_lz4_data  <= '0;
            r_lz4_wr    <= 1'b0;
            r_blk_done  <= 1'b0;
            r_done      <= 1'b0;
            r_total     <= '0;
        end else if (start_decompress) begin
            // New stream (or abort): drop everything in flight.
            r_state     <= S_WAIT_LEN;
            r_pack      <= '0;
            r_bcnt      <= '0;
            r_rem       <= '0;
            r_pend      <= 1'b0;
            r_end       <= 1'b0;
            r_lz4_wr    <= 1'b0;
            r_blk_done  <= 1'b0;
            r_done      <= 1'b0;
            r_total     <= '0;
        end else begin
            r_lz4_wr   <= 1'b0;
            r_blk_done <= 1'b0;

            // Drain the pending word; a byte accepted below may refill the slot.
            if (w_wr_go) begin
                r_lz4_wr   <= 1'b1;
                r_lz4_data <= {r_pend_cnt, r_pend_data};
                r_pend     <= 1'b0;
                if (r_state == S_FLUSH) begin
                    r_blk_done <= 1'b1;
                    if (r_end) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_WAIT_LEN;
                    end
                end
            end

            case (r_state)
                S_WAIT_LEN: begin
                    if (block_len_valid && (block_len != '0)) begin
                        r_rem   <= block_len;
                        r_state <= S_PACK;
                    end
                end
                S_PACK: begin
                    if (w_accept) begin
                        r_total <= r_total + 32'd1;
                        r_rem   <= w_rem_dec;
                        if (w_word_done) begin
                            r_pend      <= 1'b1;
                            r_pend_data <= w_word;
                            r_pend_cnt  <= CNT_W'(w_bcnt_inc - BCNT_W'(1));
                            r_pack      <= '0;
                            r_bcnt      <= '0;
                            if (w_last_blk || hd_end) begin
                                r_state <= S_FLUSH;
                                r_end   <= hd_end;
                            end
                        end else begin
                            r_pack <= w_word;
                            r_bcnt <= w_bcnt_inc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign hd_ready    = w_hd_ready;
    assign lz4_data    = r_lz4_data;
    assign lz4_wr      = r_lz4_wr;
    assign blk_done    = r_blk_done;
    assign done        = r_done;
    assign total_bytes = r_total;

endmodule

// File: tb/tb_decomp_cascade_logic.sv
// Scoreboard bench for decomp_cascade_logic: stimulus pushes expected FIFO
// words, a negedge monitor pops and compares on every lz4_wr.
module tb_decomp_cascade_logic;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        start_decompress = 1'b0;
    logic [16:0] block_len = '0;
    logic        block_len_valid = 1'b0;
    logic [7:0]  hd_data = '0;
    logic        hd_valid = 1'b0;
    logic        hd_end = 1'b0;
    logic        hd_ready;
    logic [33:0] lz4_data;
    logic        lz4_wr;
    logic        lz4_full = 1'b0;
    logic        blk_done;
    logic        done;
    logic [31:0] total_bytes;

    decomp_cascade_logic dut (
        .clk              (clk),
        .rstN             (rstN),
        .start_decompress (start_decompress),
        .block_len        (block_len),
        .block_len_valid  (block_len_valid),
        .hd_data          (hd_data),
        .hd_valid         (hd_valid),
        .hd_end           (hd_end),
        .hd_ready         (hd_ready),
        .lz4_data         (lz4_data),
        .lz4_wr           (lz4_wr),
        .lz4_full         (lz4_full),
        .blk_done         (blk_done),
        .done             (done),
        .total_bytes      (total_bytes)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [33:0] data;
        logic        blk;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_wr  = 0;
    int   n_blk = 0;
    int   wr_snap;
    int   blk_snap;
    logic full_at_edge = 1'b0;
    bit   hung = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] cnt, input logic [31:0] d, input logic b);
        exp_t pe;
        pe.data = {cnt, d};
        pe.blk  = b;
        q.push_back(pe);
    endtask

    // FIFO-full level seen by the DUT at each edge, to catch writes while full.
    always @(posedge clk) full_at_edge <= lz4_full;

    // Monitor: every FIFO write is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (rstN) begin
            if (blk_done) n_blk++;
            if (lz4_wr) begin
                n_wr++;
                check("wr_while_full", 64'(full_at_edge), 64'd0);
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_wr: got write %h, expected no write (t=%0t)", lz4_data, $time);
                end else begin
                    mon_e = q.pop_front();
                    check("lz4_data", 64'(lz4_data), 64'(mon_e.data));
                    check("blk_done_with_wr", 64'(blk_done), 64'(mon_e.blk));
                end
            end else if (blk_done) begin
                n_cmp++;
                n_bad++;
                $display("FAIL blk_done_alone: got blk_done=1 without lz4_wr, expected 0 (t=%0t)", $time);
            end
        end
    end

    // All tasks below are entered and left just after a falling edge.
    task automatic pulse_start();
        start_decompress = 1'b1;
        @(negedge clk);
        start_decompress = 1'b0;
    endtask

    task automatic give_len(input logic [16:0] len);
        block_len       = len;
        block_len_valid = 1'b1;
        @(negedge clk);
        block_len_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic e);
        int w;
        w = 0;
        if (hung) return;
        hd_data  = d;
        hd_valid = 1'b1;
        hd_end   = e;
        #1;
        while (!hd_ready && w < 64) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!hd_ready) begin
            n_cmp++;
            n_bad++;
            hung = 1'b1;
            $display("FAIL send_timeout: byte %h not accepted, expected hd_ready within 64 cycles", d);
            hd_valid = 1'b0;
            hd_end   = 1'b0;
            @(negedge clk);
            return;
        end
        @(negedge clk);
        hd_valid = 1'b0;
        hd_end   = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int w;
        w = 0;
        while (q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: got %0d words outstanding, expected 0", name, q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_hd_ready"}, 64'(hd_ready), 64'd0);
        check({tag, "_lz4_wr"}, 64'(lz4_wr), 64'd0);
        check({tag, "_lz4_data"}, 64'(lz4_data), 64'd0);
        check({tag, "_blk_done"}, 64'(blk_done), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_total"}, 64'(total_bytes), 64'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle behaviour.
        #2;
        check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_hd_ready", 64'(hd_ready), 64'd0);
        pulse_start();
        check("waitlen_hd_ready", 64'(hd_ready), 64'd0);
        give_len(17'd0);
        check("len0_ignored", 64'(hd_ready), 64'd0);

        // Two full words in an 8-byte block.
        give_len(17'd8);
        check("pack_hd_ready", 64'(hd_ready), 64'd1);
        push(2'd3, 32'h04030201, 1'b0);
        push(2'd3, 32'h08070605, 1'b1);
        blk_snap = n_blk;
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
        wait_drain("full");
        check("full_total", 64'(total_bytes), 64'd8);
        check("full_back_to_waitlen", 64'(hd_ready), 64'd0);
        check("full_blk_count", 64'(n_blk - blk_snap), 64'd1);
        check("full_done", 64'(done), 64'd0);

        // Partial word at block end.
        give_len(17'd6);
        push(2'd3, 32'hA3A2A1A0, 1'b0);
        push(2'd1, 32'h0000A5A4, 1'b1);
        for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i), 1'b0);
        wait_drain("partial");
        check("partial_total", 64'(total_bytes), 64'd14);

        // Early stream end; a length strobe while packing must be ignored.
        pulse_start();
        check("restart_total", 64'(total_bytes), 64'd0);
        give_len(17'd100);
        push(2'd2, 32'h00332211, 1'b1);
        send_byte(8'h11, 1'b0);
        give_len(17'd1);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        wait_drain("early");
        check("early_done", 64'(done), 64'd1);
        check("early_hd_ready", 64'(hd_ready), 64'd0);
        check("early_total", 64'(total_bytes), 64'd3);

        // Backpressure: first word held while the FIFO is full.
        pulse_start();
        check("bp_done_cleared", 64'(done), 64'd0);
        give_len(17'd16);
        for (int w = 0; w < 4; w++)
            push(2'd3, {8'(8'h43 + 4*w), 8'(8'h42 + 4*w), 8'(8'h41 + 4*w), 8'(8'h40 + 4*w)}, (w == 3));
        lz4_full = 1'b1;
        wr_snap  = n_wr;
        fork
            begin
                repeat (9) @(negedge clk);
                #1;
                check("bp_hd_ready", 64'(hd_ready), 64'd0);
                check("bp_no_wr", 64'(n_wr - wr_snap), 64'd0);
                check("bp_total_stalled", 64'(total_bytes), 64'd4);
                @(negedge clk);
                lz4_full = 1'b0;
            end
        join_none
        for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i), 1'b0);
        wait_drain("bp");
        check("bp_total", 64'(total_bytes), 64'd16);
        check("bp_wr_count", 64'(n_wr - wr_snap), 64'd4);

        // Maximum block length.
        pulse_start();
        give_len(17'd65536);
        wr_snap  = n_wr;
        blk_snap = n_blk;
        for (int i = 0; i < 65536; i++) begin
            if ((i % 4) == 3)
                push(2'd3, {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)}, (i == 65535));
            send_byte(8'(i), 1'b0);
        end
        wait_drain("max");
        check("max_wr_count", 64'(n_wr - wr_snap), 64'd16384);
        check("max_blk_count", 64'(n_blk - blk_snap), 64'd1);
        check("max_total", 64'(total_bytes), 64'd65536);
        check("max_waitlen", 64'(hd_ready), 64'd0);

        // Abort with a partial word in the pack register.
        pulse_start();
        give_len(17'd8);
        push(2'd3, 32'h04030201, 1'b0);
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0);
        wait_drain("abortA_pre");
        pulse_start();
        check("abortA_total", 64'(total_bytes), 64'd0);
        check("abortA_hd_ready", 64'(hd_ready), 64'd0);
        give_len(17'd3);
        push(2'd2, 32'h00776655, 1'b1);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        send_byte(8'h77, 1'b1);
        wait_drain("abortA_post");
        check("abortA_done", 64'(done), 64'd1);

        // Abort with the final word pending behind a full FIFO.
        pulse_start();
        give_len(17'd4);
        lz4_full = 1'b1;
        wr_snap  = n_wr;
        for (int i = 1; i <= 4; i++) send_byte(8'(8'hC0 + i), 1'b0);
        repeat (3) @(negedge clk);
        pulse_start();
        lz4_full = 1'b0;
        repeat (5) @(negedge clk);
        check("abortB_dropped", 64'(n_wr - wr_snap), 64'd0);
        check("abortB_total", 64'(total_bytes), 64'd0);
        check("abortB_hd_ready", 64'(hd_ready), 64'd0);
        check("abortB_done", 64'(done), 64'd0);

        // Asynchronous reset in the middle of a block.
        pulse_start();
        give_len(17'd8);
        push(2'd3, 32'h04030201, 1'b0);
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
        wait_drain("midreset");
        #3;
        rstN = 1'b0;
        #1;
        check_zero("midreset");
        @(negedge clk);
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_hd_ready", 64'(hd_ready), 64'd0);
        pulse_start();
        check("post_reset_waitlen", 64'(hd_ready), 64'd0);
        give_len(17'd4);
        check("post_reset_pack", 64'(hd_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
